// File: rtl/qpsk_rx_timing.sv
// rtl/qpsk_rx_timing.sv - QPSK symbol timing: carrier-pulse symbol boundaries, I/Q integrate-and-dump, output FIFO
module qpsk_rx_timing #(
    parameter int SAMPLE_W   = 16,
    parameter int ACC_W      = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       msf_carrier_pulse,
    input  logic [12:0]                msf_cp_per_bit,
    input  logic                       one_sec_pulse,
    input  logic                       qpsk_rx_enable,
    input  logic signed [SAMPLE_W-1:0] s_i,
    input  logic signed [SAMPLE_W-1:0] s_q,
    input  logic                       s_valid,
    output logic signed [ACC_W-1:0]    m_sym_i,
    output logic signed [ACC_W-1:0]    m_sym_q,
    output logic [7:0]                 m_sym_index,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic                       rx_locked,
    output logic                       overflow,
    output logic                       slip
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT_SEC, INTEGRATE} state_t;

    state_t                  state;
    logic [12:0]             carrier_cnt;
    logic [7:0]              sym_index;
    logic signed [ACC_W-1:0] acc_i, acc_q;
    logic signed [ACC_W-1:0] fifo_i [FIFO_DEPTH];
    logic signed [ACC_W-1:0] fifo_q [FIFO_DEPTH];
    logic [7:0]              fifo_idx [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr, rd_ptr;
    logic [CNT_W-1:0]        fifo_cnt;

    logic                    marker, boundary, push, pop, push_ok;
    logic signed [ACC_W-1:0] ext_i, ext_q, sum_i, sum_q;

    assign marker   = msf_carrier_pulse & one_sec_pulse;
    // cp_per_bit of 0 or 1 must not underflow the compare: every pulse ends a symbol
    assign boundary = msf_carrier_pulse &&
                      ((msf_cp_per_bit <= 13'd1) || (carrier_cnt >= msf_cp_per_bit - 13'd1));
    assign push     = (state == INTEGRATE) && boundary;
    assign pop      = m_valid && m_ready;
    assign push_ok  = push && ((fifo_cnt != DEPTH_C) || pop);

    assign ext_i = ACC_W'(s_i);
    assign ext_q = ACC_W'(s_q);
    assign sum_i = acc_i + (s_valid ? ext_i : '0);
    assign sum_q = acc_q + (s_valid ? ext_q : '0);

    assign m_valid     = (fifo_cnt != '0);
    assign m_sym_i     = m_valid ? fifo_i[rd_ptr] : '0;
    assign m_sym_q     = m_valid ? fifo_q[rd_ptr] : '0;
    assign m_sym_index = m_valid ? fifo_idx[rd_ptr] : 8'd0;
    assign rx_locked   = (state == INTEGRATE);

    always_ff @(posedge clk) begin
        if (rst || !qpsk_rx_enable) begin
            state       <= IDLE;
            carrier_cnt <= '0;
            sym_index   <= '0;
            acc_i       <= '0;
            acc_q       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            overflow    <= 1'b0;
            slip        <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= WAIT_SEC;
                WAIT_SEC: begin
                    if (marker) begin
                        state       <= INTEGRATE;
                        carrier_cnt <= '0;
                        sym_index   <= '0;
                        acc_i       <= '0;
                        acc_q       <= '0;
                    end
                end
                INTEGRATE: begin
                    if (boundary) begin
                        // a marker on a boundary keeps the finished symbol, then restarts numbering
                        carrier_cnt <= '0;
                        acc_i       <= '0;
                        acc_q       <= '0;
                        sym_index   <= marker ? 8'd0 : sym_index + 8'd1;
                    end else if (marker) begin
                        carrier_cnt <= '0;
                        sym_index   <= '0;
                        acc_i       <= '0;
                        acc_q       <= '0;
                        if (carrier_cnt != '0)
                            slip <= 1'b1;
                    end else begin
                        acc_i <= sum_i;
                        acc_q <= sum_q;
                        if (msf_carrier_pulse)
                            carrier_cnt <= carrier_cnt + 13'd1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (push_ok) begin
                fifo_i[wr_ptr]   <= sum_i;
                fifo_q[wr_ptr]   <= sum_q;
                fifo_idx[wr_ptr] <= sym_index;
                wr_ptr           <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (push && !push_ok)
                overflow <= 1'b1;
            if (pop)
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;

            case ({push_ok, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_qpsk_rx_timing.sv
// tb/tb_qpsk_rx_timing.sv - scoreboard bench for qpsk_rx_timing with directed vectors
module tb_qpsk_rx_timing;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               msf_carrier_pulse = 1'b0;
    logic [12:0]        msf_cp_per_bit = 13'd4;
    logic               one_sec_pulse = 1'b0;
    logic               qpsk_rx_enable = 1'b0;
    logic signed [15:0] s_i = '0;
    logic signed [15:0] s_q = '0;
    logic               s_valid = 1'b0;
    logic signed [31:0] m_sym_i, m_sym_q;
    logic [7:0]         m_sym_index;
    logic               m_valid;
    logic               m_ready = 1'b1;
    logic               rx_locked, overflow, slip;

    typedef struct {
        int i;
        int q;
        int idx;
    } sym_t;

    sym_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    qpsk_rx_timing #(.SAMPLE_W(16), .ACC_W(32), .FIFO_DEPTH(2)) dut (
        .clk               (clk),
        .rst               (rst),
        .msf_carrier_pulse (msf_carrier_pulse),
        .msf_cp_per_bit    (msf_cp_per_bit),
        .one_sec_pulse     (one_sec_pulse),
        .qpsk_rx_enable    (qpsk_rx_enable),
        .s_i               (s_i),
        .s_q               (s_q),
        .s_valid           (s_valid),
        .m_sym_i           (m_sym_i),
        .m_sym_q           (m_sym_q),
        .m_sym_index       (m_sym_index),
        .m_valid           (m_valid),
        .m_ready           (m_ready),
        .rx_locked         (rx_locked),
        .overflow          (overflow),
        .slip              (slip)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int i, input int q, input int idx);
        sym_t e;
        e.i = i;
        e.q = q;
        e.idx = idx;
        exp_q.push_back(e);
    endtask

    // one clock cycle with the given strobes; returns 1 time unit after the edge
    task automatic cyc(input bit cp, input bit sec, input bit sv, input int si, input int sq);
        msf_carrier_pulse = cp;
        one_sec_pulse     = sec;
        s_valid           = sv;
        s_i               = 16'(si);
        s_q               = 16'(sq);
        @(posedge clk);
        #1;
        msf_carrier_pulse = 1'b0;
        one_sec_pulse     = 1'b0;
        s_valid           = 1'b0;
    endtask

    task automatic relock();
        qpsk_rx_enable = 1'b0;
        cyc(0, 0, 0, 0, 0);
        qpsk_rx_enable = 1'b1;
        cyc(0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_symbol: got i=%0d q=%0d idx=%0d, expected none", m_sym_i, m_sym_q, m_sym_index);
            end else begin
                sym_t e;
                e = exp_q.pop_front();
                check("sym_i", m_sym_i, e.i);
                check("sym_q", m_sym_q, e.q);
                check("sym_index", m_sym_index, e.idx);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) cyc(0, 0, 0, 0, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_rx_locked", rx_locked, 0);
        check("rst_sym_i", m_sym_i, 0);
        check("rst_overflow", overflow, 0);
        check("rst_slip", slip, 0);
        rst = 1'b0;

        // two symbols of four pulses
        msf_cp_per_bit = 13'd4;
        m_ready = 1'b1;
        relock();
        check("locked_after_marker", rx_locked, 1);
        push_exp(4, -8, 0);
        push_exp(4, -8, 1);
        for (int k = 0; k < 8; k++) begin
            cyc(1, 0, 1, 1, -2);
            if (k == 2) check("valid_before_boundary", m_valid, 0);
            if (k == 3) check("valid_after_boundary", m_valid, 1);
        end
        repeat (2) cyc(0, 0, 0, 0, 0);

        // marker mid-symbol: partial discarded, slip, numbering restarts
        cyc(1, 0, 1, 3, 5);
        cyc(1, 0, 1, 3, 5);
        cyc(1, 1, 0, 0, 0);
        check("slip_set", slip, 1);
        check("no_push_on_slip", m_valid, 0);
        push_exp(18, -4, 0);
        cyc(0, 0, 1, 10, 0);
        repeat (4) cyc(1, 0, 1, 2, -1);
        repeat (2) cyc(0, 0, 0, 0, 0);

        // overflow with consumer stalled
        msf_cp_per_bit = 13'd2;
        m_ready = 1'b0;
        relock();
        check("slip_cleared_by_enable", slip, 0);
        push_exp(2, 14, 0);
        push_exp(10, -6, 1);
        repeat (2) cyc(1, 0, 1, 1, 7);
        repeat (2) cyc(1, 0, 1, 5, -3);
        check("no_overflow_two_entries", overflow, 0);
        repeat (2) cyc(1, 0, 1, 9, 9);
        check("overflow_set", overflow, 1);
        check("held_sym_i", m_sym_i, 2);
        check("held_sym_q", m_sym_q, 14);
        check("held_sym_index", m_sym_index, 0);
        m_ready = 1'b1;
        repeat (3) cyc(0, 0, 0, 0, 0);
        check("overflow_sticky", overflow, 1);
        check("drained", m_valid, 0);
        qpsk_rx_enable = 1'b0;
        cyc(0, 0, 0, 0, 0);
        check("overflow_cleared", overflow, 0);

        // one symbol per pulse, index wrap, marker on a boundary
        msf_cp_per_bit = 13'd0;
        relock();
        for (int j = 0; j < 260; j++) begin
            if (j == 130) msf_cp_per_bit = 13'd1;
            push_exp(j + 1, -(j + 1), j % 256);
            cyc(1, 0, 1, j + 1, -(j + 1));
        end
        push_exp(7, -7, 4);
        cyc(1, 1, 1, 7, -7);
        push_exp(9, -9, 0);
        cyc(1, 0, 1, 9, -9);
        repeat (2) cyc(0, 0, 0, 0, 0);
        check("no_slip_on_boundary_marker", slip, 0);
        check("no_overflow_streaming", overflow, 0);

        // full-scale accumulation without wrap
        msf_cp_per_bit = 13'd8191;
        relock();
        push_exp(-268402688, 268394497, 0);
        for (int k = 0; k < 8191; k++) cyc(1, 0, 1, -32768, 32767);
        check("valid_after_long_symbol", m_valid, 1);
        repeat (2) cyc(0, 0, 0, 0, 0);

        // reset mid-symbol with one FIFO entry
        msf_cp_per_bit = 13'd4;
        m_ready = 1'b0;
        relock();
        repeat (6) cyc(1, 0, 1, 1, 1);
        check("entry_held_before_rst", m_valid, 1);
        rst = 1'b1;
        cyc(0, 0, 0, 0, 0);
        check("rst2_m_valid", m_valid, 0);
        check("rst2_rx_locked", rx_locked, 0);
        check("rst2_sym_i", m_sym_i, 0);
        check("rst2_sym_q", m_sym_q, 0);
        check("rst2_sym_index", m_sym_index, 0);
        rst = 1'b0;
        repeat (3) cyc(1, 0, 1, 1, 1);
        check("no_lock_without_marker", rx_locked, 0);
        check("no_valid_after_rst", m_valid, 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
